store_serializer: RTL and testbench
===================================

# store_serializer

Store-side counterpart of the load-path sign extender. It accepts a 32-bit register value with a store size (byte, halfword or word) and narrows it to the addressed width. It then writes it big-endian as byte-wide beats to the data-memory write port, using valid/ready handshakes on both sides. It sits between the EX/MEM stage store request and the byte-wide data memory.

## Interface
- ADDR_W, 32, width of request and memory addresses
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  store request present
- req_ready  out  1  block can accept a request
- req_addr  in  ADDR_W  byte address of the store
- req_data  in  32  register value to store
- req_size  in  2  00 byte (sb), 01 halfword (sh), 10 word (sw), 11 illegal
- mem_wr_valid  out  1  write beat present
- mem_wr_ready  in  1  memory accepts beat
- mem_wr_addr  out  ADDR_W  byte address of current beat
- mem_wr_data  out  8  byte of current beat
- done  out  1  one-cycle pulse, store fully written
- misalign_err  out  1  one-cycle pulse, request rejected

## Operation
- States: IDLE, SEND. Reset forces IDLE. req_ready = (state == IDLE), combinational from state.
- Request accept: req_valid && req_ready at a rising edge.
- Legality check at accept:
  - size 11 is illegal.
  - size 01 is illegal with addr[0]=1.
  - size 10 is illegal with addr[1:0]≠00.
  - An illegal request produces misalign_err=1 for the next cycle only, performs no memory write, and the block stays in IDLE.
- Legal accept: latch shift buffer, base address, beat count; go to SEND.
  - byte: buf = {req_data[7:0], 24'b0}, count 1
  - half: buf = {req_data[15:0], 16'b0}, count 2
  - word: buf = req_data, count 4
  - Upper bits of req_data beyond the store width are discarded (narrowing; no overflow check).
- SEND: mem_wr_valid=1, mem_wr_data=buf[31:24], mem_wr_addr=current address. Big-endian: the most significant byte of the narrowed value goes to the lowest address.
- Beat handshake (mem_wr_valid && mem_wr_ready):
  - buf <<= 8, address += 1, count -= 1.
  - On the last beat, go to IDLE and pulse done=1 in the following cycle.
- While mem_wr_ready=0, mem_wr_valid, mem_wr_addr and mem_wr_data hold stable.
- Address increment wraps modulo 2^ADDR_W. This cannot occur for aligned legal requests.

## Timing
- Reset values (rst_n=0 at an edge): state IDLE, mem_wr_valid 0, mem_wr_addr 0, mem_wr_data 0, done 0, misalign_err 0, count 0, buf 0. req_ready reads 1 once the state is IDLE.
- Reset mid-SEND aborts the store: no further beats, no done pulse.
- Accept at edge k: mem_wr_valid=1 from cycle k+1.
- With mem_wr_ready tied 1, a store of n beats occupies cycles k+1..k+n. done=1 in cycle k+n+1, when req_ready is also 1.
- Back-to-back stores: a new request can be accepted at the edge ending the done cycle. There is no accept during SEND.
- misalign_err and done are never asserted together.
- req_valid with rst_n=0 is ignored.

## Test plan
- sw addr 0x100, data 0xDEADBEEF, ready=1 -> beats (0x100,DE),(0x101,AD),(0x102,BE),(0x103,EF) on consecutive cycles; done one cycle after the last beat.
- sh addr 0x202, data 0x1234ABCD -> beats (0x202,AB),(0x203,CD); 0x1234 never appears on mem_wr_data.
- sb addr 0x7, data 0xFFFFFF80; mem_wr_ready low for 3 cycles -> (0x7,0x80) held stable 4 cycles; one handshake; done pulses once.
- sw addr 0x102, then sh addr 0x1, then size 11 -> misalign_err pulses once per request, mem_wr_valid stays 0, req_ready stays 1.
- sw in flight, rst_n=0 after beat 2 -> next cycle mem_wr_valid=0, state IDLE, no done; a following sb completes normally.

Source files
------------

// File: rtl/store_serializer.sv
// store_serializer: narrows a store to sb/sh/sw width and writes it big-endian as byte beats
module store_serializer #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              mem_wr_valid,
  input  logic              mem_wr_ready,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [7:0]        mem_wr_data,
  output logic              done,
  output logic              misalign_err
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;
  logic [31:0] buf_q, buf_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0] cnt_q, cnt_d;
  logic done_q, done_d, err_q, err_d;
  logic accept, legal, beat;
  assign req_ready = state_q == IDLE;
  assign mem_wr_valid = state_q == SEND;
  assign mem_wr_addr = addr_q;
  assign mem_wr_data = buf_q[31:24];
  assign done = done_q;
  assign misalign_err = err_q;
  assign accept = req_valid && req_ready;
  assign beat = mem_wr_valid && mem_wr_ready;
  assign legal = (req_size == 2'b00) || (req_size == 2'b01 && !req_addr[0]) ||
                 (req_size == 2'b10 && req_addr[1:0] == 2'b00);
  always_comb begin
    state_d = state_q;
    buf_d = buf_q;
    addr_d = addr_q;
    cnt_d = cnt_q;
    done_d = 1'b0;
    err_d = 1'b0;
    if (accept && !legal) begin
      err_d = 1'b1;
    end else if (accept) begin
      state_d = SEND;
      addr_d = req_addr;
      buf_d = req_size == 2'b00 ? {req_data[7:0], 24'b0} :
              req_size == 2'b01 ? {req_data[15:0], 16'b0} : req_data;
      cnt_d = req_size == 2'b00 ? 3'd1 : req_size == 2'b01 ? 3'd2 : 3'd4;
    end else if (beat) begin
      buf_d = {buf_q[23:0], 8'b0};
      addr_d = addr_q + ADDR_W'(1);
      cnt_d = cnt_q - 3'd1;
      if (cnt_q == 3'd1) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      buf_q <= '0;
      addr_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q <= buf_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_store_serializer.sv
// tb_store_serializer: directed vectors for store_serializer, sampled on the falling edge
module tb_store_serializer;
  logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, mem_wr_ready = 1'b1;
  logic req_ready, mem_wr_valid, done, misalign_err;
  logic [31:0] req_addr = '0, req_data = '0, mem_wr_addr;
  logic [1:0] req_size = '0;
  logic [7:0] mem_wr_data;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  store_serializer #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .done(done), .misalign_err(misalign_err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    req_valid = 1'b1;
    req_addr = a;
    req_data = d;
    req_size = s;
    @(negedge clk);
    req_valid = 1'b0;
  endtask
  task automatic beat(input logic [31:0] a, input logic [7:0] d);
    check("beat_valid", {31'b0, mem_wr_valid}, 1);
    check("beat_addr", mem_wr_addr, a);
    check("beat_data", {24'b0, mem_wr_data}, {24'b0, d});
    check("beat_ready", {31'b0, req_ready}, 0);
    check("beat_done", {31'b0, done}, 0);
  endtask
  task automatic finish_store();
    check("done_pulse", {31'b0, done}, 1);
    check("done_ready", {31'b0, req_ready}, 1);
    check("done_valid", {31'b0, mem_wr_valid}, 0);
    check("done_err", {31'b0, misalign_err}, 0);
    @(negedge clk);
    check("done_low", {31'b0, done}, 0);
  endtask
  logic [31:0] bad_addr [3] = '{32'h102, 32'h1, 32'h0};
  logic [1:0]  bad_size [3] = '{2'b10, 2'b01, 2'b11};
  initial begin
    @(negedge clk);
    req_valid = 1'b1;
    req_size = 2'b10;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 1);
    check("rst_valid", {31'b0, mem_wr_valid}, 0);
    check("rst_addr", mem_wr_addr, 0);
    check("rst_data", {24'b0, mem_wr_data}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_err", {31'b0, misalign_err}, 0);
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    send(32'h100, 32'hDEADBEEF, 2'b10);
    beat(32'h100, 8'hDE); @(negedge clk);
    beat(32'h101, 8'hAD); @(negedge clk);
    beat(32'h102, 8'hBE); @(negedge clk);
    beat(32'h103, 8'hEF); @(negedge clk);
    finish_store();
    send(32'h202, 32'h1234ABCD, 2'b01);
    beat(32'h202, 8'hAB); @(negedge clk);
    beat(32'h203, 8'hCD); @(negedge clk);
    finish_store();
    mem_wr_ready = 1'b0;
    send(32'h7, 32'hFFFFFF80, 2'b00);
    for (int i = 0; i < 3; i++) begin
      beat(32'h7, 8'h80);
      @(negedge clk);
    end
    mem_wr_ready = 1'b1;
    beat(32'h7, 8'h80);
    @(negedge clk);
    finish_store();
    check("sb_no_repeat", {31'b0, mem_wr_valid}, 0);
    for (int i = 0; i < 3; i++) begin
      send(bad_addr[i], 32'hCAFEF00D, bad_size[i]);
      check("err_pulse", {31'b0, misalign_err}, 1);
      check("err_valid", {31'b0, mem_wr_valid}, 0);
      check("err_ready", {31'b0, req_ready}, 1);
      check("err_done", {31'b0, done}, 0);
      @(negedge clk);
      check("err_low", {31'b0, misalign_err}, 0);
      check("err_valid2", {31'b0, mem_wr_valid}, 0);
    end
    send(32'h300, 32'h11223344, 2'b10);
    beat(32'h300, 8'h11); @(negedge clk);
    beat(32'h301, 8'h22); @(negedge clk);
    beat(32'h302, 8'h33);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_valid", {31'b0, mem_wr_valid}, 0);
    check("abort_ready", {31'b0, req_ready}, 1);
    check("abort_done", {31'b0, done}, 0);
    check("abort_addr", mem_wr_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_done2", {31'b0, done}, 0);
    check("abort_valid2", {31'b0, mem_wr_valid}, 0);
    send(32'h10, 32'h0000005A, 2'b00);
    beat(32'h10, 8'h5A); @(negedge clk);
    finish_store();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
